// File: rtl/alu_issue_if.sv
// -----------------------------------------------------------------------------
// alu_issue_if
// Purpose : groups the operation-issue handshake (upstream side) and the
//           result handshake (consumer side) of alu_issue_stage.
// Signals : in_valid/in_ready/in_op/in_a/in_b  - operation offer
//           res_valid/res_ready/res_data/res_op/res_zero - result delivery
// Modports: slave  - the issue stage itself
//           master - the environment (producer + consumer)
// -----------------------------------------------------------------------------
interface alu_issue_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [2:0]       res_op;
    logic             res_zero;

    modport slave (
        input  in_valid, in_op, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_op, res_zero
    );

    modport master (
        output in_valid, in_op, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_op, res_zero
    );
endinterface

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Purpose : queues incoming ALU operations, issues them one at a time to an
//           external combinational ALU from stable operand registers, and
//           holds each captured result until the consumer accepts it.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           bus (slave)     - operation and result handshakes (alu_issue_if)
//           alu_opcode      - opcode to the ALU (from operand register)
//           alu_in1/alu_in2 - operands to the ALU (from operand registers)
//           alu_out         - combinational ALU result
//           err_op          - sticky illegal-opcode flag
//           clr_err         - synchronous clear of err_op
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_if.slave       bus,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out,
    output logic             err_op,
    input  logic             clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [2:0]    OP_NEG   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [2:0]        r_mem_op [DEPTH];
    logic [WIDTH-1:0]  r_mem_a  [DEPTH];
    logic [WIDTH-1:0]  r_mem_b  [DEPTH];
    logic [2:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_res_valid;
    logic [WIDTH-1:0]  r_res_data;
    logic [2:0]        r_res_op;
    logic              r_err_op;
    logic              w_push;
    logic              w_pop;
    logic              w_in_ready;
    logic              w_illegal;

    // No bypass: a full queue refuses the offer even if the head pops this cycle.
    assign w_in_ready = (r_count < DEPTH_C);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_illegal  = (r_op > OP_NEG);

    assign bus.in_ready  = w_in_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_op    = r_res_op;
    assign bus.res_zero  = (r_res_data == {WIDTH{1'b0}});
    assign alu_opcode    = r_op;
    assign alu_in1       = r_a;
    assign alu_in2       = r_b;
    assign err_op        = r_err_op;

    // Next-state and pop decision of the issue FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != CNT_ZERO) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    if (r_count != CNT_ZERO) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= CNT_ZERO;
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= bus.in_op;
            r_mem_a[r_wr_ptr]  <= bus.in_a;
            r_mem_b[r_wr_ptr]  <= bus.in_b;
        end
    end

    // Operand registers feeding the ALU; only reloaded on a pop, so they stay
    // stable through EXEC and HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 3'd0;
            r_a  <= {WIDTH{1'b0}};
            r_b  <= {WIDTH{1'b0}};
        end else if (w_pop) begin
            r_op <= r_mem_op[r_rd_ptr];
            r_a  <= r_mem_a[r_rd_ptr];
            r_b  <= r_mem_b[r_rd_ptr];
        end
    end

    // Result capture in EXEC; valid drops when the consumer takes it in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= {WIDTH{1'b0}};
            r_res_op    <= 3'd0;
        end else if (r_state == ST_EXEC) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_illegal ? {WIDTH{1'b0}} : alu_out;
            r_res_op    <= r_op;
        end else if ((r_state == ST_HOLD) && bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // Sticky error flag; a set in EXEC takes priority over a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_op <= 1'b0;
        end else if ((r_state == ST_EXEC) && w_illegal) begin
            r_err_op <= 1'b1;
        end else if (clr_err) begin
            r_err_op <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of operation-queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 in_op  input  3  opcode: 0 plus, 1 minus, 2 AND, 3 OR, 4 negate in1; 5-7 illegal.
REQ-008 in_a, in_b  input  WIDTH each  operands.
REQ-009 alu_opcode  output  3  opcode to the downstream combinational ALU.
REQ-010 alu_in1, alu_in2  output  WIDTH each  operands to the ALU.
REQ-011 alu_out  input  WIDTH  ALU result, combinational from alu_opcode/alu_in1/alu_in2.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 res_data  output  WIDTH  captured result.
REQ-015 res_op  output  3  opcode that produced res_data.
REQ-016 res_zero  output  1  high when res_data == 0.
REQ-017 err_op  output  1  sticky illegal-opcode flag.
REQ-018 clr_err  input  1  synchronous clear of err_op.

Function
REQ-019 An operation SHALL be accepted only on a rising edge where in_valid && in_ready, and written to the queue tail.
REQ-020 in_ready SHALL equal (count < DEPTH), with no same-cycle pass-through when full.
REQ-021 A simultaneous push and pop SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-022 The control FSM SHALL have states IDLE, EXEC and HOLD.
REQ-023 IDLE: if count > 0, pop the head into the operand registers and go to EXEC; otherwise stay.
REQ-024 alu_opcode/alu_in1/alu_in2 SHALL be driven only from the operand registers, stable for the whole of EXEC and HOLD.
REQ-025 EXEC (exactly one cycle): capture res_data = alu_out, res_op = operand opcode, assert res_valid, go to HOLD.
REQ-026 For opcodes 5-7, EXEC SHALL capture res_data = 0 instead of alu_out and set err_op on the same edge.
REQ-027 HOLD: res_data/res_op/res_valid SHALL stay constant until res_ready is high.
REQ-028 HOLD with res_ready: if count > 0, pop the next entry and go to EXEC, with res_valid low for the EXEC cycle; else drop res_valid and go to IDLE.
REQ-029 Latency: an operation accepted at edge E into an empty, idle block SHALL show res_valid high after edge E+2.
REQ-030 Throughput with res_ready tied high SHALL be one result every 2 cycles.
REQ-031 Arithmetic SHALL be modulo 2^WIDTH; carry and borrow are discarded.
REQ-032 err_op SHALL stay set until clr_err is sampled high; if set and clear occur on the same edge, set wins.
REQ-033 res_zero SHALL be combinational from res_data.

Reset
REQ-034 While rst_n is low: state = IDLE; count and pointers = 0; in_ready = 1; res_valid = 0; res_data = 0; res_op = 0; err_op = 0; operand registers and alu_* = 0.
REQ-035 Reset asserted mid-operation SHALL discard all queued and in-flight operations with no result emitted; queue storage contents need no reset.

Verification
REQ-036 Single op: push op=0, a=8'hF0, b=8'h20, res_ready=1 -> res_data=8'h10, res_op=0, res_zero=0, res_valid high 2 edges after accept.
REQ-037 Fill/backpressure: res_ready=0, push 5 ops (first op=1, a=5, b=5) -> in_ready low after the 4th queued entry; first result 8'h00 with res_zero=1, held stable for 10 cycles; then all 5 results drain in order.
REQ-038 Illegal opcode: push op=6 -> res_data=0 and err_op=1, sticky across later legal ops; pulse clr_err -> err_op=0 next edge.
REQ-039 Simultaneous push/pop at count=2 -> count remains 2; 8 pointer wraps with no lost or duplicated ops (scoreboard check).
REQ-040 Reset mid-HOLD with 3 queued ops: drop rst_n -> res_valid=0 and in_ready=1 immediately; no stale result after release.
REQ-041 Negate: op=4, a=8'h5A, b=8'hFF -> res_data=8'hA5.
